uart_rx_sequencer: RTL and testbench

//  - UART receive controller driven by the 16x oversampling tick from baudrate_generator.
//  - Synchronises the serial input, detects the start bit and samples each bit at mid-bit.
//  - Assembles an LSB-first byte, checks the stop bit and hands the byte to the debug/loader unit.
//  - Sequences the shared tick resource: counts ticks per bit; ignores ticks while idle.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rx_sync_2ff.sv | 25 ++
 rtl/uart_rx_sequencer.sv | 134 +++++++++++++
 tb/tb_uart_rx_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and default framing.
// Used by the RX sequencer, the TX side and the baud-rate generator.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_OVERSAMPLING = 16;
    localparam int DEF_NB_DATA      = 8;
    localparam int DEF_SB_TICK      = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input; resets to 1 so an idle-high
// line does not produce a false edge when reset is released.
module rx_sync_2ff (
    input  logic clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= i_async;
            sync_reg <= meta_reg;
        end
    end

    assign o_sync = sync_reg;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receiver: start-bit detect, mid-bit sampling on the oversampling tick, LSB-first
// assembly and stop-bit check. Ticks are only consumed while a frame is in progress.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int NB_DATA      = DEF_NB_DATA,
    parameter int OVERSAMPLING = DEF_OVERSAMPLING,
    parameter int SB_TICK      = DEF_SB_TICK
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int S_W = $clog2(max_int(OVERSAMPLING, SB_TICK));
    localparam int N_W = $clog2(NB_DATA);

    localparam logic [S_W-1:0] HALF_LAST = S_W'(OVERSAMPLING / 2 - 1);
    localparam logic [S_W-1:0] BIT_LAST  = S_W'(OVERSAMPLING - 1);
    localparam logic [S_W-1:0] STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] DATA_LAST = N_W'(NB_DATA - 1);

    logic rx_s;

    uart_state_t        state_reg, state_next;
    logic [S_W-1:0]     s_cnt_reg, s_cnt_next;
    logic [N_W-1:0]     n_cnt_reg, n_cnt_next;
    logic [NB_DATA-1:0] shift_reg, shift_next;
    logic               frame_end;

    rx_sync_2ff u_rx_sync (
        .clk     (clk),
        .i_reset (i_reset),
        .i_async (i_rx),
        .o_sync  (rx_s)
    );

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
            s_cnt_reg <= '0;
            n_cnt_reg <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            s_cnt_reg <= s_cnt_next;
            n_cnt_reg <= n_cnt_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_cnt_next = s_cnt_reg;
        n_cnt_next = n_cnt_reg;
        shift_next = shift_reg;
        frame_end  = 1'b0;

        case (state_reg)
            // Start edge is taken immediately so the half-bit count is measured from it.
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_cnt_next = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_cnt_reg == HALF_LAST) begin
                        s_cnt_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            n_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_cnt_reg == BIT_LAST) begin
                        s_cnt_next = '0;
                        shift_next = {rx_s, shift_reg[NB_DATA-1:1]};
                        if (n_cnt_reg == DATA_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_cnt_next = n_cnt_reg + N_W'(1);
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_cnt_reg == STOP_LAST) begin
                        state_next = IDLE;
                        s_cnt_next = '0;
                        frame_end  = 1'b1;
                    end else begin
                        s_cnt_next = s_cnt_reg + S_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte and error flag are captured together so they are coherent with the done pulse.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done <= frame_end;
            if (frame_end) begin
                o_data      <= shift_reg;
                o_frame_err <= ~rx_s;
            end
        end
    end

    assign o_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed and random frame bench for uart_rx_sequencer: a tick every 10 clks,
// 160 clks per bit, expected bytes kept in a queue and matched against each done pulse.
module tb_uart_rx_sequencer;

    localparam int BIT_CLKS = 160;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   exp_frames = 0;
    bit   tick_en = 1'b1;
    exp_t exp_q[$];
    int   done_cyc[$];
    logic [7:0] last_data = 8'h00;

    always #5 clk = ~clk;

    uart_rx_sequencer #(
        .NB_DATA      (8),
        .OVERSAMPLING (16),
        .SB_TICK      (16)
    ) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick strobe: one clk high in ten; the phase freezes while ticks are stalled.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                ph = (ph == 9) ? 0 : ph + 1;
                i_tick = (ph == 0);
            end else begin
                i_tick = 1'b0;
            end
        end
    end

    // Every done pulse is matched against the oldest expected frame.
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_done) check("done_width", {31'd0, o_rx_done}, 32'd0);
            if (o_rx_done === 1'b1) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("rx frame %0d: data=%02h ferr=%0b (want %02h/%0b)",
                             done_cnt, o_data, o_frame_err, e.data, e.ferr);
                    check("rx_data", {24'd0, o_data}, {24'd0, e.data});
                    check("rx_ferr", {31'd0, o_frame_err}, {31'd0, e.ferr});
                    last_data = e.data;
                end
            end
            prev_done = o_rx_done;
        end
    end

    task automatic drive_bit(input logic b, input int clks);
        i_rx = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        drive_bit(1'b1, n * BIT_CLKS);
    endtask

    // A bad stop bit is held low only long enough to be sampled, so the line is back
    // high before the receiver's follow-on start check and no phantom frame appears.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        exp_q.push_back('{data: data, ferr: ~stop});
        exp_frames++;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLKS);
        if (stop) begin
            drive_bit(1'b1, BIT_CLKS);
        end else begin
            drive_bit(1'b0, 120);
            drive_bit(1'b1, 40);
        end
    endtask

    task automatic wait_done(input int target);
        int budget;
        budget = 2000;
        while (done_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("done_count", done_cnt, target);
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        int         gap;
        int         n;

        // Reset state, checked before any clock edge.
        i_reset = 1'b1;
        #2 i_reset = 1'b0;
        #1;
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_done", {31'd0, o_rx_done}, 32'd0);
        check("rst_ferr", {31'd0, o_frame_err}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        idle_bits(1);

        // Good frame.
        send_frame(8'hA5, 1'b1);
        wait_done(1);
        check("t1_busy_after", {31'd0, o_busy}, 32'd0);
        check("t1_data", {24'd0, o_data}, 32'h0000_00A5);
        idle_bits(1);

        // Start glitch of three ticks.
        drive_bit(1'b0, 30);
        check("t2_busy_in_start", {31'd0, o_busy}, 32'd1);
        drive_bit(1'b1, 120);
        check("t2_busy_back_idle", {31'd0, o_busy}, 32'd0);
        check("t2_no_done", done_cnt, 32'd1);
        check("t2_data_held", {24'd0, o_data}, {24'd0, last_data});
        idle_bits(1);

        // Framing error, then a good frame clears the flag.
        send_frame(8'h3C, 1'b0);
        idle_bits(1);
        wait_done(2);
        check("t3_ferr_set", {31'd0, o_frame_err}, 32'd1);
        check("t3_ferr_data", {24'd0, o_data}, 32'h0000_003C);
        send_frame(8'h11, 1'b1);
        wait_done(3);
        check("t3_ferr_clear", {31'd0, o_frame_err}, 32'd0);
        idle_bits(1);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_done(5);
        n = done_cyc.size();
        gap = done_cyc[n-1] - done_cyc[n-2];
        $display("back-to-back done spacing: %0d clks", gap);
        check("t4_gap", {31'd0, (gap >= 1590 && gap <= 1610)}, 32'd1);
        idle_bits(1);

        // Reset in the middle of data bit 4; partial byte must vanish.
        d = 8'h5A;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(d[4], 80);
        #3 i_reset = 1'b0;
        #1;
        check("t5_rst_data", {24'd0, o_data}, 32'd0);
        check("t5_rst_done", {31'd0, o_rx_done}, 32'd0);
        check("t5_rst_ferr", {31'd0, o_frame_err}, 32'd0);
        check("t5_rst_busy", {31'd0, o_busy}, 32'd0);
        last_data = 8'h00;
        i_rx = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        idle_bits(1);
        check("t5_no_done", done_cnt, 32'd5);
        send_frame(8'h5A, 1'b1);
        wait_done(6);
        idle_bits(1);

        // Tick stall mid-bit 3; the line bit is stretched by the same amount.
        d = 8'hC3;
        exp_q.push_back('{data: d, ferr: 1'b0});
        exp_frames++;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(d[3], 80);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        check("t6_busy_stalled", {31'd0, o_busy}, 32'd1);
        check("t6_no_done_stalled", done_cnt, 32'd6);
        tick_en = 1'b1;
        drive_bit(d[3], 80);
        for (int i = 4; i < 8; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        wait_done(7);
        idle_bits(1);

        // Random bytes, random stop-bit errors and idle gaps.
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            idle_bits(gap);
        end
        idle_bits(1);
        wait_done(exp_frames);
        check("all_consumed", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, o_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
